// File: rtl/ascon_ctrl_pkg.sv
// Shared types and constants for the Ascon frame controller.
package ascon_ctrl_pkg;

    localparam int         FRAME_BYTES = 184;
    localparam int         TAG_BYTES   = 16;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLOCK_W     = 1472;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        START,
        WAIT,
        SEND_C,
        SEND_T,
        ERR
    } state_t;

    // LSB position of frame byte k; byte 0 sits at the top of the block.
    function automatic int byte_lsb(input int k);
        return BLOCK_W - 8 * (k + 1);
    endfunction

endpackage

// File: rtl/ascon_tx_serializer.sv
// Captures ciphertext and tag from the core and streams them out as bytes,
// MSB byte first, over a valid/ready handshake. Padding bytes are skipped.
module ascon_tx_serializer
    import ascon_ctrl_pkg::*;
#(
    parameter int N_DATA_P = 181
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     load,
    input  logic [BLOCK_W-1:0]       cipher,
    input  logic [8*TAG_BYTES-1:0]   tag,
    input  logic                     m_ready,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    output logic                     cipher_done,
    output logic                     done
);

    localparam int TOTAL = N_DATA_P + TAG_BYTES;
    localparam int CNT_W = $clog2(TOTAL + 1);

    logic [BLOCK_W-1:0]     sh;
    logic [8*TAG_BYTES-1:0] tag_q;
    logic [CNT_W-1:0]       cnt;
    logic                   active;
    logic                   take;

    assign take        = active & m_ready;
    assign cipher_done = take && (cnt == CNT_W'(N_DATA_P - 1));
    assign done        = take && (cnt == CNT_W'(TOTAL - 1));
    assign m_data      = sh[BLOCK_W-1 -: 8];
    assign m_valid     = active;

    // Load on core completion, shift one byte per handshake; the tag replaces
    // the top of the shifter right after the last ciphertext byte leaves.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            sh     <= '0;
            tag_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            sh     <= cipher;
            tag_q  <= tag;
            cnt    <= '0;
            active <= 1'b1;
        end else if (take) begin
            cnt <= cnt + CNT_W'(1);
            if (cipher_done) begin
                sh <= {tag_q, {(BLOCK_W - 8*TAG_BYTES){1'b0}}};
            end else begin
                sh <= {sh[BLOCK_W-9:0], 8'h00};
            end
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ascon_frame_ctrl.sv
// Frame sequencer in front of the Ascon-128 AEAD core: gathers a padded
// frame, starts the core, streams ciphertext + tag, advances the nonce.
// Optional build macro ASCON_TIMEOUT_EN bounds WAIT with a fault timer.
//
// state  | meaning
// FILL   | accept payload bytes into the frame buffer
// PAD    | write the 10* pad byte after the payload
// START  | one-cycle start pulse to the core
// WAIT   | frame and nonce held until the core finishes
// SEND_C | stream ciphertext bytes
// SEND_T | stream tag bytes, then advance nonce and frame count
// ERR    | core timeout, sticky until reset
module ascon_frame_ctrl
    import ascon_ctrl_pkg::*;
#(
    parameter int N_DATA_P  = 181,
    parameter int TIMEOUT_P = 4096
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [7:0]             s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [7:0]             m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    input  logic [127:0]           nonce_init_i,
    input  logic                   nonce_load_i,
    output logic                   start_o,
    output logic [BLOCK_W-1:0]     plain_text_o,
    output logic [127:0]           nonce_o,
    input  logic                   end_ascon_i,
    input  logic [BLOCK_W-1:0]     cipher_i,
    input  logic [8*TAG_BYTES-1:0] tag_i,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic                   err_o
);

    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    if (N_DATA_P < 1 || N_DATA_P >= FRAME_BYTES || TIMEOUT_P < 2) begin : g_cfg_check
        $error("ascon_frame_ctrl: N_DATA_P must be 1..183 and TIMEOUT_P >= 2");
    end

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [BLOCK_W-1:0] frame_q;
    logic [127:0]       nonce_q;
    logic [15:0]        frame_cnt_q;
    logic               accept;
    logic               ser_load;
    logic               ser_cipher_done;
    logic               ser_done;

    assign accept       = s_valid_i && (state == FILL);
    assign ser_load     = (state == WAIT) && end_ascon_i;
    assign plain_text_o = frame_q;
    assign nonce_o      = nonce_q;
    assign frame_cnt_o  = frame_cnt_q;

`ifdef ASCON_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_P);

    logic [TMR_W-1:0] tmr;
    logic             tmr_tc;

    assign tmr_tc = (tmr == '0);

    // Loaded in START so that err_o rises TIMEOUT_P cycles after the start pulse.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            tmr <= '0;
        end else if (state == START) begin
            tmr <= TMR_W'(TIMEOUT_P - 2);
        end else if (state == WAIT && !tmr_tc) begin
            tmr <= tmr - TMR_W'(1);
        end
    end
`endif

    // State register.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && idx == IDX_W'(N_DATA_P - 1)) state_nxt = PAD;
            PAD:     state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (end_ascon_i) begin
                    state_nxt = SEND_C;
                end
`ifdef ASCON_TIMEOUT_EN
                else if (tmr_tc) begin
                    state_nxt = ERR;
                end
`endif
            end
            SEND_C:  if (ser_cipher_done) state_nxt = SEND_T;
            SEND_T:  if (ser_done) state_nxt = FILL;
            ERR:     state_nxt = ERR;
            default: state_nxt = FILL;
        endcase
    end

    // Moore outputs.
    always_comb begin
        s_ready_o = (state == FILL);
        start_o   = (state == START);
        busy_o    = (state != FILL);
`ifdef ASCON_TIMEOUT_EN
        err_o     = (state == ERR);
`else
        err_o     = 1'b0;
`endif
    end

    // Frame buffer, byte index, nonce and frame counter.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            idx         <= '0;
            frame_q     <= '0;
            nonce_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (nonce_load_i && idx == '0) begin
                        nonce_q <= nonce_init_i;
                    end
                    if (accept) begin
                        frame_q[byte_lsb(int'(idx)) +: 8] <= s_data_i;
                        idx <= idx + IDX_W'(1);
                    end
                end
                PAD: frame_q[byte_lsb(N_DATA_P) +: 8] <= PAD_BYTE;
                SEND_T: begin
                    if (ser_done) begin
                        nonce_q     <= nonce_q + 128'd1;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        frame_q     <= '0;
                        idx         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    ascon_tx_serializer #(
        .N_DATA_P(N_DATA_P)
    ) u_tx (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .load        (ser_load),
        .cipher      (cipher_i),
        .tag         (tag_i),
        .m_ready     (m_ready_i),
        .m_data      (m_data_o),
        .m_valid     (m_valid_o),
        .cipher_done (ser_cipher_done),
        .done        (ser_done)
    );

endmodule
